if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Parametrised next-generation instruction-fetch stage.
- Owns a registered PC and issues requests to the icache over a valid/ready handshake.
- Tracks outstanding requests and buffers returned instructions, with their PCs, in an in-order fetch queue of FQ_DEPTH entries.
- Decode consumes from the queue via a valid/ready handshake. An EX-stage redirect flushes the queue, and any in-flight responses are discarded by drop-counting.

Parameters:
- ADDR_W, 32, PC/address width (`CPU_ADDR_BITS).
- DATA_W, 32, instruction word width (`CPU_DATA_BITS).
- PC_RESET, 32'h0000_2000, PC loaded on reset (`PC_RESET).
- FQ_DEPTH, 4, fetch-queue entries; power of two, >=2; also the maximum number of outstanding requests.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset); deassertion is synchronous to clk.
- redirect_valid  in  1  EX-stage taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  redirect target (ALU result).
- icache_req_valid  out  1  fetch request valid.
- icache_req_ready  in  1  icache accepts the request.
- icache_addr  out  ADDR_W  fetch address (current PC register).
- icache_resp_valid  in  1  in-order response valid; one per accepted request.
- icache_resp_data  in  DATA_W  returned instruction.
- inst_valid  out  1  queue head holds a filled instruction.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  head PC.
- inst_ready  in  1  decode accepts the head (deasserted on decode stall).

Behaviour:
- Reset (reset=0, async): pc=PC_RESET; queue pointers, occupancy, outstanding and drop_cnt all 0.
  - Outputs during reset: icache_req_valid=0, icache_addr=PC_RESET, inst_valid=0, inst_data=0, inst_pc=0.
- Accounting:
  - occ = allocated queue slots, including those awaiting data.
  - credit = FQ_DEPTH - occ.
  - icache_req_valid = (credit>0). It is registered-output-derived, with no combinational path from redirect_valid.
- Request accept (valid&&ready):
  - Allocate the slot at wr_ptr and store pc in it with filled=0.
  - wr_ptr++ and pc <= pc+4; wrap is modulo 2^ADDR_W.
- Response (resp_valid):
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Else: write data into the slot at fill_ptr, set filled=1, fill_ptr++.
  - A response with no outstanding request is illegal; a bench assertion fires on it.
- Pop:
  - inst_valid = (occ>0) && slot[rd_ptr].filled.
  - inst_valid&&inst_ready pops the head: rd_ptr++, occ--.
  - inst_data/inst_pc are driven from the head slot.
- Redirect (redirect_valid=1), effective at the next edge:
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}; misaligned low bits are forced to zero.
  - All queue slots are invalidated; occ, rd/wr/fill pointers all return to 0.
  - drop_cnt <= (requests accepted but not yet responded, including one accepted in this same cycle) minus (a response arriving this same cycle).
  - A pop in the redirect cycle still completes: decode sees that instruction. The flush overrides the pop's effect on the pointers.
  - The first request to the new PC may be issued the cycle after redirect, even while drop_cnt>0.
  - Stale responses are dropped before any new response is filled, which holds because responses are in order.
- Simultaneous accept, response and pop in one cycle: all take effect; occ updates by +1 (accept) -1 (pop).
- Full (credit=0): icache_req_valid=0 and pc holds.
- Empty or head unfilled: inst_valid=0.
- Async reset mid-operation: immediate return to the reset values above. Responses from pre-reset requests are the icache's responsibility; the icache is reset by the same signal.
- Latency: a response arriving at edge N is visible on inst_valid in the cycle after edge N (one-cycle fill-to-issue). Minimum request-to-decode latency is icache latency + 1.

Decomposition:
- const.vh: `CPU_ADDR_BITS, `CPU_DATA_BITS, `PC_RESET, and new `FQ_DEPTH_DEFAULT.
- Sub-module if_fetch_queue: slot array, three pointers, filled bits, occ, and flush input.
- The parent if_fetch_unit holds the pc register, the credit/outstanding/drop_cnt counters and the redirect logic.
- The existing adder and mux_2input are not reused. The pc increment and select are inline in the parent because of the registered next-state.

Test Plan:
- Reset release, icache ready=1 with 1-cycle latency, inst_ready=1.
  -> Requests at 0x2000, 0x2004, 0x2008…
  -> inst_pc follows the same sequence with matching data, one instruction per cycle after fill.
- inst_ready=0 held, FQ_DEPTH=4.
  -> Exactly 4 requests are accepted (0x2000–0x200C), then icache_req_valid=0 and icache_addr holds 0x2010.
  -> Raising inst_ready for one cycle pops 0x2000 and one new request at 0x2010 follows.
- Two requests outstanding (3-cycle icache latency), then redirect_pc=0x3001.
  -> Next address is 0x3000 and drop_cnt=2.
  -> The two old responses are discarded; the first inst_pc seen after flush is 0x3000.
- Redirect in the same cycle a request to 0x2008 is accepted and a response arrives.
  -> drop_cnt is computed correctly.
  -> The 0x2008 response is dropped and no stale PC ever appears on inst_pc.
- icache_req_ready toggling 0/1 randomly, inst_ready random, 1000 instructions.
  -> inst_pc is strictly sequential and data matches the icache model, with no drops or duplicates.
- reset asserted mid-stream with queue full.
  -> Outputs return to reset values within the same cycle.
  -> After release, the first request is to 0x2000.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset PC and sizing defaults for the instruction-fetch stage.
package if_fetch_unit_pkg;
  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_DATA_BITS = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_2000;
  localparam int FQ_DEPTH_DEFAULT = 4;
  // Extra headroom bits on the in-flight counters: back-to-back redirects can stack
  // stale requests beyond FQ_DEPTH, bounded only by the icache's own capacity.
  localparam int INFLIGHT_EXTRA_BITS = 3;

  function automatic int occ_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: redirect input, icache request/response and decode handshake.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_BITS,
  parameter int DATA_W = CPU_DATA_BITS
) ();
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              icache_req_valid;
  logic              icache_req_ready;
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_resp_valid;
  logic [DATA_W-1:0] icache_resp_data;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, icache_req_ready, icache_resp_valid,
           icache_resp_data, inst_ready,
    output icache_req_valid, icache_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, icache_req_ready, icache_resp_valid,
           icache_resp_data, inst_ready,
    input  icache_req_valid, icache_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order fetch queue: slots are allocated at request time (PC only) and
// filled later by icache responses; the head pops only once filled.
module if_fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_BITS,
  parameter int DATA_W = CPU_DATA_BITS,
  parameter int DEPTH  = FQ_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_alloc,
  input  logic [ADDR_W-1:0]          i_alloc_pc,
  input  logic                       i_fill,
  input  logic [DATA_W-1:0]          i_fill_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [occ_bits(DEPTH)-1:0] o_occ,
  output logic                       o_head_valid,
  output logic [DATA_W-1:0]          o_head_data,
  output logic [ADDR_W-1:0]          o_head_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_bits(DEPTH);

  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr, r_fill_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic [ADDR_W-1:0] r_slot_pc     [DEPTH];
  logic [DATA_W-1:0] r_slot_data   [DEPTH];
  logic              r_slot_filled [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_occ      <= '0;
    end else if (i_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_occ      <= '0;
    end else begin
      if (i_alloc) r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      if (i_fill)  r_fill_ptr <= r_fill_ptr + PTR_W'(1);
      if (i_pop)   r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
      r_occ <= r_occ + OCC_W'(i_alloc) - OCC_W'(i_pop);
    end
  end

  // Alloc and fill never hit the same slot: that would need wr_ptr==fill_ptr,
  // i.e. either nothing awaiting data or a full queue that blocks allocation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot_pc[i]     <= '0;
        r_slot_data[i]   <= '0;
        r_slot_filled[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_flush) begin
          r_slot_filled[i] <= 1'b0;
        end else if (i_alloc && (r_wr_ptr == PTR_W'(i))) begin
          r_slot_pc[i]     <= i_alloc_pc;
          r_slot_filled[i] <= 1'b0;
        end else if (i_fill && (r_fill_ptr == PTR_W'(i))) begin
          r_slot_data[i]   <= i_fill_data;
          r_slot_filled[i] <= 1'b1;
        end
      end
    end
  end

  assign o_occ        = r_occ;
  assign o_head_valid = (r_occ != '0) && r_slot_filled[r_rd_ptr];
  assign o_head_data  = r_slot_data[r_rd_ptr];
  assign o_head_pc    = r_slot_pc[r_rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, credit-based icache requests, and
// drop-counting of responses still in flight when a redirect flushes the queue.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_BITS,
  parameter int                DATA_W   = CPU_DATA_BITS,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_DEFAULT),
  parameter int                FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  if_fetch_unit_if.master if_bus
);
  localparam int OCC_W = occ_bits(FQ_DEPTH);
  localparam int CNT_W = OCC_W + INFLIGHT_EXTRA_BITS;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic [OCC_W-1:0]  w_occ;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_resp_drop;
  logic              w_fill;
  logic              w_head_valid;
  logic              w_pop;
  logic [CNT_W-1:0]  w_inflight_next;

  // Credit comes from registered occupancy only; reset gates it so no request
  // escapes while the block is held in reset.
  assign w_req_valid     = reset && (w_occ < OCC_W'(FQ_DEPTH));
  assign w_accept        = w_req_valid && if_bus.icache_req_ready;
  assign w_resp_drop     = if_bus.icache_resp_valid && (r_drop_cnt != '0);
  assign w_fill          = if_bus.icache_resp_valid && (r_drop_cnt == '0);
  assign w_pop           = w_head_valid && if_bus.inst_ready;
  assign w_inflight_next = r_outstanding + CNT_W'(w_accept) - CNT_W'(if_bus.icache_resp_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= PC_RESET;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_inflight_next;
      if (if_bus.redirect_valid) begin
        r_pc       <= {if_bus.redirect_pc[ADDR_W-1:2], 2'b00};
        r_drop_cnt <= w_inflight_next;
      end else begin
        if (w_accept)    r_pc       <= r_pc + ADDR_W'(4);
        if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  if_fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FQ_DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_alloc      (w_accept),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_data  (if_bus.icache_resp_data),
    .i_pop        (w_pop),
    .i_flush      (if_bus.redirect_valid),
    .o_occ        (w_occ),
    .o_head_valid (w_head_valid),
    .o_head_data  (if_bus.inst_data),
    .o_head_pc    (if_bus.inst_pc)
  );

  assign if_bus.icache_req_valid = w_req_valid;
  assign if_bus.icache_addr      = r_pc;
  assign if_bus.inst_valid       = w_head_valid;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: an in-order icache model feeds responses,
// the expected decode stream is built from accepted requests, a monitor compares pops.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] PCR   = 32'h0000_2000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  if_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .PC_RESET (PCR),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .if_bus (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
  typedef struct { logic [31:0] addr; int due; } req_t;

  inst_t       exp_q [$];   // instructions decode should see, in order
  req_t        pend_q[$];   // requests the icache owes a response for
  logic [31:0] model_pc;
  int          cyc = 0, last_due = 0, lat = 1, due;
  int          n_checks = 0, n_errors = 0, n_pops = 0;
  bit          drop_chk = 1'b0;
  int          drop_exp = 0;
  inst_t       e;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: credit output and every decode pop are checked against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("req_valid", 32'(bus.icache_req_valid), 32'(exp_q.size() < DEPTH));
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_inst: got pc %h expected no instruction", bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", bus.inst_pc, e.pc);
          chk("inst_data", bus.inst_data, e.data);
          n_pops++;
          $display("pop  pc=%h data=%h", bus.inst_pc, bus.inst_data);
        end
      end
    end
  end

  // Stimulus bookkeeping: runs after the monitor in each cycle.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (drop_chk) begin
        chk("drop_cnt", 32'(dut.r_drop_cnt), 32'(drop_exp));
        drop_chk = 1'b0;
      end
      if (bus.icache_resp_valid) begin
        assert (pend_q.size() > 0) else $error("icache response with no outstanding request");
        if (pend_q.size() > 0) void'(pend_q.pop_front());
      end
      if (bus.icache_req_valid && bus.icache_req_ready) begin
        chk("req_addr", bus.icache_addr, model_pc);
        due = (last_due + 1 > cyc + 1 + lat) ? last_due + 1 : cyc + 1 + lat;
        pend_q.push_back('{addr: bus.icache_addr, due: due});
        last_due = due;
        if (!bus.redirect_valid) begin
          exp_q.push_back('{pc: model_pc, data: mem(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        model_pc = {bus.redirect_pc[31:2], 2'b00};
        drop_chk = 1'b1;
        drop_exp = pend_q.size();
      end
    end
  end

  task automatic drive_resp();
    if (reset && pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
      bus.icache_resp_valid = 1'b1;
      bus.icache_resp_data  = mem(pend_q[0].addr);
    end else begin
      bus.icache_resp_valid = 1'b0;
      bus.icache_resp_data  = $urandom;
    end
  endtask

  task automatic step(input bit rr, input bit ir, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    bus.icache_req_ready = rr;
    bus.inst_ready       = ir;
    bus.redirect_valid   = rv;
    bus.redirect_pc      = rpc;
    drive_resp();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.icache_req_ready  = 1'b0;
    bus.inst_ready        = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.icache_resp_valid = 1'b0;
    bus.icache_resp_data  = '0;
    pend_q.delete();
    exp_q.delete();
    drop_chk = 1'b0;
    model_pc = PCR;
    last_due = 0;
    #1;
    chk("rst_req_valid", 32'(bus.icache_req_valid), 32'd0);
    chk("rst_addr", bus.icache_addr, PCR);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("post_rst_req_valid", 32'(bus.icache_req_valid), 32'd1);
    chk("post_rst_addr", bus.icache_addr, PCR);
  endtask

  int p0;

  initial begin
    bus.icache_req_ready  = 1'b0;
    bus.inst_ready        = 1'b0;
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.icache_resp_valid = 1'b0;
    bus.icache_resp_data  = '0;
    model_pc = PCR;

    // Streaming: 1-cycle icache, decode always ready.
    lat = 1;
    do_reset();
    p0 = n_pops;
    repeat (30) step(1'b1, 1'b1, 1'b0, '0);
    chk("stream_throughput", 32'((n_pops - p0) >= 25), 32'd1);

    // Decode stalled: queue fills with four requests, then credit runs out.
    do_reset();
    repeat (12) step(1'b1, 1'b0, 1'b0, '0);
    chk("full_req_valid", 32'(bus.icache_req_valid), 32'd0);
    chk("full_addr", bus.icache_addr, 32'h2010);
    chk("full_head_pc", bus.inst_pc, 32'h2000);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("refill_addr", bus.icache_addr, 32'h2014);
    chk("refill_req_valid", 32'(bus.icache_req_valid), 32'd0);

    // Reset while full (checked inside do_reset), then a 3-cycle icache with
    // two requests in flight when a misaligned redirect arrives.
    lat = 3;
    do_reset();
    for (int k = 0; k < 20 && bus.icache_addr != 32'h2008; k++) step(1'b1, 1'b1, 1'b0, '0);
    bus.icache_req_ready = 1'b0;
    bus.redirect_valid   = 1'b1;
    bus.redirect_pc      = 32'h3001;
    step(1'b0, 1'b1, 1'b0, '0);
    chk("redir_addr", bus.icache_addr, 32'h3000);
    chk("redir_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
    repeat (25) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect in the same cycle as an accept (0x2008), a response and a pop.
    lat = 1;
    do_reset();
    for (int k = 0; k < 20 && bus.icache_addr != 32'h2008; k++) step(1'b1, 1'b1, 1'b0, '0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4000;
    step(1'b1, 1'b1, 1'b0, '0);
    chk("race_addr", bus.icache_addr, 32'h4000);
    chk("race_drop_cnt", 32'(dut.r_drop_cnt), 32'd1);
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);

    // Random handshakes and icache latency, 1000 instructions.
    do_reset();
    p0 = n_pops;
    for (int k = 0; k < 20000 && (n_pops - p0) < 1000; k++) begin
      lat = $urandom_range(1, 4);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, '0);
    end
    chk("random_count", 32'((n_pops - p0) >= 1000), 32'd1);
    repeat (10) step(1'b0, 1'b1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
